// File: rtl/dither_frame_sequencer_if.sv
// FIFO-side and ditherer-side signals of the frame sequencer, grouped as one bus.
// master = sequencer, slave = FIFO/ditherer environment.
interface dither_frame_sequencer_if #(
    parameter int unsigned WIDTH_BITS = 12
);
    logic [WIDTH_BITS:0] fifo_level;
    logic [7:0]          fifo_data;
    logic                fifo_rd;
    logic [7:0]          dith_in;
    logic                dith_in_valid;
    logic                dith_hsync;
    logic                dith_vsync;

    modport master (
        input  fifo_level,
        input  fifo_data,
        output fifo_rd,
        output dith_in,
        output dith_in_valid,
        output dith_hsync,
        output dith_vsync
    );

    modport slave (
        output fifo_level,
        output fifo_data,
        input  fifo_rd,
        input  dith_in,
        input  dith_in_valid,
        input  dith_hsync,
        input  dith_vsync
    );
endinterface

// File: rtl/dither_frame_sequencer.sv
// Releases Y8 lines from a FWFT FIFO into the error diffusion ditherer one full line at a time,
// generating vsync at frame start and a late hsync after each line's blanking.
module dither_frame_sequencer #(
    parameter int unsigned VSYNC_CYCLES = 2,
    parameter int unsigned MIN_HBLANK   = 4,
    parameter int unsigned WIDTH_BITS   = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [WIDTH_BITS-1:0] i_cfg_width,
    input  logic [WIDTH_BITS-1:0] i_cfg_height,
    input  logic [7:0]            i_cfg_hblank,
    dither_frame_sequencer_if.master io_bus,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_underrun_err
);

    typedef enum logic [2:0] {StIdle, StVsync, StWait, StActive, StHblank, StDone} state_e;

    localparam int unsigned VsBits = (VSYNC_CYCLES > 1) ? $clog2(VSYNC_CYCLES) : 1;
    localparam logic [VsBits-1:0] VsLast = VsBits'(VSYNC_CYCLES - 1);
    localparam logic [7:0] MinHblank = 8'(MIN_HBLANK);
    localparam logic [WIDTH_BITS-1:0] One = WIDTH_BITS'(1);

    state_e                r_state;
    logic [WIDTH_BITS-1:0] r_width;
    logic [WIDTH_BITS-1:0] r_height;
    logic [7:0]            r_hblank;
    logic [WIDTH_BITS-1:0] r_pix_cnt;
    logic [WIDTH_BITS-1:0] r_line_cnt;
    logic [7:0]            r_hb_cnt;
    logic [VsBits-1:0]     r_vs_cnt;
    logic                  r_fifo_rd;
    logic [7:0]            r_din;
    logic                  r_valid;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_underrun;

    logic [7:0]            w_hblank;
    logic                  w_level_ok;
    logic                  w_pop_empty;
    logic [WIDTH_BITS-1:0] w_line_nxt;

    assign w_hblank    = (i_cfg_hblank < MinHblank) ? MinHblank : i_cfg_hblank;
    assign w_level_ok  = io_bus.fifo_level >= {1'b0, r_width};
    assign w_pop_empty = r_fifo_rd && (io_bus.fifo_level == '0);
    assign w_line_nxt  = r_line_cnt + One;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_width      <= '0;
            r_height     <= '0;
            r_hblank     <= '0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_hb_cnt     <= '0;
            r_vs_cnt     <= '0;
            r_fifo_rd    <= 1'b0;
            r_din        <= '0;
            r_valid      <= 1'b0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else if (i_abort) begin
            // The pop issued this cycle still happened upstream; only its output is dropped.
            if (w_pop_empty) r_underrun <= 1'b1;
            r_state      <= StIdle;
            r_fifo_rd    <= 1'b0;
            r_din        <= '0;
            r_valid      <= 1'b0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= r_fifo_rd;
            r_din        <= (r_fifo_rd && !w_pop_empty) ? io_bus.fifo_data : 8'h00;
            r_frame_done <= 1'b0;
            if (w_pop_empty) r_underrun <= 1'b1;

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_width    <= i_cfg_width;
                        r_height   <= i_cfg_height;
                        r_hblank   <= w_hblank;
                        r_underrun <= 1'b0;
                        r_busy     <= 1'b1;
                        if (i_cfg_width == '0 || i_cfg_height == '0) begin
                            r_state      <= StDone;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state  <= StVsync;
                            r_vsync  <= 1'b1;
                            r_vs_cnt <= '0;
                        end
                    end
                end
                StVsync: begin
                    if (r_vs_cnt == VsLast) begin
                        r_vsync    <= 1'b0;
                        r_line_cnt <= '0;
                        r_state    <= StWait;
                    end else begin
                        r_vs_cnt <= r_vs_cnt + 1'b1;
                    end
                end
                StWait: begin
                    if (w_level_ok) begin
                        r_state   <= StActive;
                        r_fifo_rd <= 1'b1;
                        r_pix_cnt <= '0;
                    end
                end
                StActive: begin
                    if (r_pix_cnt == r_width - One) begin
                        r_fifo_rd <= 1'b0;
                        r_hb_cnt  <= '0;
                        r_state   <= StHblank;
                    end else begin
                        r_pix_cnt <= r_pix_cnt + One;
                    end
                end
                StHblank: begin
                    // hsync is registered, so it is raised one count early to land in the last cycle.
                    if (r_hb_cnt == r_hblank - 8'd2) r_hsync <= 1'b1;
                    if (r_hb_cnt == r_hblank - 8'd1) begin
                        r_hsync    <= 1'b0;
                        r_line_cnt <= w_line_nxt;
                        if (w_line_nxt == r_height) begin
                            r_state      <= StDone;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= StWait;
                        end
                    end else begin
                        r_hb_cnt <= r_hb_cnt + 8'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.fifo_rd       = r_fifo_rd;
    assign io_bus.dith_in       = r_din;
    assign io_bus.dith_in_valid = r_valid;
    assign io_bus.dith_hsync    = r_hsync;
    assign io_bus.dith_vsync    = r_vsync;
    assign o_busy               = r_busy;
    assign o_frame_done         = r_frame_done;
    assign o_underrun_err       = r_underrun;

endmodule
